// File: rtl/alu_sequencer.sv
// alu_sequencer: command-side initiator for an 8-bit combinational ALU.
// Commands are buffered in a small FIFO and issued one at a time. Each one is
// held on the ALU inputs for SETTLE cycles before result and NZVC are captured.
// Captured results are returned in order over a valid/ready response port.
module alu_sequencer #(
   parameter int DEPTH  = 4,
   parameter int SETTLE = 1,
   parameter int CW     = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [7:0]               cmd_a,
   input  logic [7:0]               cmd_b,
   input  logic [2:0]               cmd_op,
   output logic [7:0]               alu_a,
   output logic [7:0]               alu_b,
   output logic [2:0]               alu_sel,
   input  logic [7:0]               alu_result,
   input  logic [3:0]               alu_nzvc,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [7:0]               rsp_result,
   output logic [3:0]               rsp_nzvc,
   output logic [3:0]               flags,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW   = $clog2(DEPTH);
   localparam int CNTW = AW + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t          state;
   state_t          state_next;

   // FIFO entry layout: {op, a, b}
   logic [18:0]     mem [DEPTH];
   logic [18:0]     head;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   settle_cnt;

   logic            push;
   logic            pop;
   logic            capture;
   logic            rsp_done;

   // No pass-through: a full FIFO refuses commands even if a pop is pending.
   assign cmd_ready = (count < CNTW'(DEPTH));
   assign push      = cmd_valid & cmd_ready;
   assign head      = mem[rd_ptr];
   assign busy      = (state != IDLE) || (count != '0);

   // FIFO storage; contents are never read unless count says they are valid
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of 2)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= AW'(wr_ptr + 1);
         end
         if (pop) begin
            rd_ptr <= AW'(rd_ptr + 1);
         end
         if (push && !pop) begin
            count <= CNTW'(count + 1);
         end else if (pop && !push) begin
            count <= CNTW'(count - 1);
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state and per-cycle strobes (pop, capture, response handshake)
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      capture    = 1'b0;
      rsp_done   = 1'b0;
      case (state)
         IDLE: begin
            if (count != '0) begin
               pop        = 1'b1;
               state_next = DRIVE;
            end
         end
         DRIVE: begin
            if (settle_cnt == '0) begin
               capture    = 1'b1;
               state_next = RESP;
            end
         end
         RESP: begin
            if (rsp_valid && rsp_ready) begin
               rsp_done = 1'b1;
               // Back-to-back issue: the next command starts on the handshake edge.
               if (count != '0) begin
                  pop        = 1'b1;
                  state_next = DRIVE;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Settle counter: loaded on every pop, counts down while the ALU inputs settle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_cnt <= '0;
      end else if (pop) begin
         settle_cnt <= CW'(SETTLE - 1);
      end else if ((state == DRIVE) && (settle_cnt != '0)) begin
         settle_cnt <= settle_cnt - CW'(1);
      end
   end

   // ALU operand/select registers; hold their last values between pops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_sel <= '0;
         alu_a   <= '0;
         alu_b   <= '0;
      end else if (pop) begin
         {alu_sel, alu_a, alu_b} <= head;
      end
   end

   // Response capture and flags; flags track the latest capture regardless of rsp_ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_nzvc   <= '0;
         flags      <= '0;
      end else if (capture) begin
         rsp_valid  <= 1'b1;
         rsp_result <= alu_result;
         rsp_nzvc   <= alu_nzvc;
         flags      <= alu_nzvc;
      end else if (rsp_done) begin
         rsp_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: a behavioural ALU is attached to two instances
// (SETTLE=1 and SETTLE=3); responses of the SETTLE=1 instance are scoreboarded.
module tb_alu_sequencer;

   localparam int DEPTH = 4;
   localparam int CNTW  = $clog2(DEPTH) + 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   // SETTLE=1 instance signals
   logic            cmd_valid = 1'b0;
   logic            cmd_ready;
   logic [7:0]      cmd_a = '0;
   logic [7:0]      cmd_b = '0;
   logic [2:0]      cmd_op = '0;
   logic [7:0]      alu_a, alu_b, alu_result;
   logic [2:0]      alu_sel;
   logic [3:0]      alu_nzvc;
   logic            rsp_valid;
   logic            rsp_ready = 1'b0;
   logic [7:0]      rsp_result;
   logic [3:0]      rsp_nzvc, flags;
   logic            busy;
   logic [CNTW-1:0] count;

   // SETTLE=3 instance signals
   logic            cmd_valid3 = 1'b0;
   logic            cmd_ready3;
   logic [7:0]      cmd_a3 = '0;
   logic [7:0]      cmd_b3 = '0;
   logic [2:0]      cmd_op3 = '0;
   logic [7:0]      alu_a3, alu_b3, alu_result3;
   logic [2:0]      alu_sel3;
   logic [3:0]      alu_nzvc3;
   logic            rsp_valid3;
   logic            rsp_ready3 = 1'b1;
   logic [7:0]      rsp_result3;
   logic [3:0]      rsp_nzvc3, flags3;
   logic            busy3;
   logic [CNTW-1:0] count3;

   alu_sequencer #(.DEPTH(DEPTH), .SETTLE(1), .CW(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_result(alu_result), .alu_nzvc(alu_nzvc),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_nzvc(rsp_nzvc),
      .flags(flags), .busy(busy), .count(count)
   );

   alu_sequencer #(.DEPTH(DEPTH), .SETTLE(3), .CW(3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
      .cmd_a(cmd_a3), .cmd_b(cmd_b3), .cmd_op(cmd_op3),
      .alu_a(alu_a3), .alu_b(alu_b3), .alu_sel(alu_sel3),
      .alu_result(alu_result3), .alu_nzvc(alu_nzvc3),
      .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
      .rsp_result(rsp_result3), .rsp_nzvc(rsp_nzvc3),
      .flags(flags3), .busy(busy3), .count(count3)
   );

   // Behavioural ALU: integer arithmetic, overflow judged by signed range
   function automatic logic [11:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
      int unsigned ua, ub;
      int          r, sa, sb, sr;
      logic        v, c;
      logic [7:0]  res;
      ua = a; ub = b; sa = $signed(a); sb = $signed(b);
      r = 0; sr = 0; v = 1'b0; c = 1'b0;
      case (op)
         3'd0: begin r = int'(ua + ub); sr = sa + sb; c = (ua + ub) > 255; end
         3'd1: begin r = int'(ua + 1);  sr = sa + 1;  c = (ua + 1) > 255; end
         3'd2: begin r = int'(ua) - int'(ub); sr = sa - sb; c = ua < ub; end
         3'd3: begin r = int'(ua) - 1;  sr = sa - 1;  c = ua < 1; end
         3'd4: r = int'(ua & ub);
         3'd5: r = int'(ua | ub);
         3'd6: r = int'(ua ^ ub);
         default: r = 255 - int'(ua);
      endcase
      if (op < 3'd4) v = (sr > 127) || (sr < -128);
      res = r[7:0];
      return {res[7], res == 8'd0, v, c, res};
   endfunction

   // ALU models attached to both instances
   always_comb {alu_nzvc, alu_result}   = alu_ref(alu_a, alu_b, alu_sel);
   always_comb {alu_nzvc3, alu_result3} = alu_ref(alu_a3, alu_b3, alu_sel3);

   logic [11:0] exp_q [$];
   int          checks   = 0;
   int          failures = 0;
   bit          mon_en   = 1'b0;
   bit          prev_stall = 1'b0;
   logic [11:0] prev_rsp = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every response handshake, checks stall stability
   always @(negedge clk) begin
      logic [11:0] e;
      if (!rst_n || !mon_en) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("rsp_valid_held", 32'(rsp_valid), 32'd1);
            check("rsp_data_held", 32'({rsp_nzvc, rsp_result}), 32'(prev_rsp));
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("rsp_nzvc_result", 32'({rsp_nzvc, rsp_result}), 32'(e));
               check("flags_at_rsp", 32'(flags), 32'(e[11:8]));
            end
         end
         prev_stall = rsp_valid && !rsp_ready;
         prev_rsp   = {rsp_nzvc, rsp_result};
      end
   end

   // Offer one command to the SETTLE=1 instance; queue its expectation when accepted
   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      int n;
      bit done;
      n = 0; done = 1'b0;
      cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (cmd_ready) begin
            exp_q.push_back(alu_ref(a, b, op));
            done = 1'b1;
         end else if (n >= 200) begin
            check("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
            done = 1'b1;
         end else begin
            n++;
         end
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_timeout", 32'(n < 3000), 32'd1);
   endtask

   // Single command into an idle instance with rsp_ready=1: checks 2-edge latency
   task automatic single(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input logic [7:0] res, input logic [3:0] nzvc);
      send(a, b, op);
      @(posedge clk); #1;
      check("lat_alu_a", 32'(alu_a), 32'(a));
      check("lat_alu_sel", 32'(alu_sel), 32'(op));
      check("lat_no_rsp_yet", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
      check("lat_rsp_valid", 32'(rsp_valid), 32'd1);
      check("lat_rsp_result", 32'(rsp_result), 32'(res));
      check("lat_rsp_nzvc", 32'(rsp_nzvc), 32'(nzvc));
      check("lat_flags", 32'(flags), 32'(nzvc));
      wait_drain();
   endtask

   initial begin
      #(50000 * 10);
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit stim_done;
      // Reset takes effect without a clock edge
      #2 rst_n = 1'b0;
      #1;
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_count", 32'(count), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_outputs", 32'({alu_a, alu_b, alu_sel, rsp_result, rsp_nzvc, flags}), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;
      rsp_ready = 1'b1;
      @(posedge clk); #1;

      // Signed overflow on add
      single(8'h7F, 8'h01, 3'b000, 8'h80, 4'b1010);

      // Two subtracts back to back; second drive starts on the first handshake edge
      send(8'h05, 8'h05, 3'b010);
      send(8'h00, 8'h01, 3'b010);
      @(posedge clk); #1;
      check("b2b_first_rsp", 32'(rsp_valid), 32'd1);
      check("b2b_first_alu_a", 32'(alu_a), 32'h05);
      @(posedge clk); #1;
      check("b2b_second_alu_a", 32'(alu_a), 32'h00);
      check("b2b_second_alu_b", 32'(alu_b), 32'h01);
      wait_drain();

      // Backpressure: FIFO fills, sixth command stalls until responses drain
      rsp_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++) send(8'(i * 37 + 3), 8'(i * 11 + 1), 3'(i));
         end
         begin
            repeat (8) @(posedge clk);
            #1;
            check("full_count", 32'(count), 32'd4);
            check("full_cmd_ready", 32'(cmd_ready), 32'd0);
            check("full_rsp_valid", 32'(rsp_valid), 32'd1);
            repeat (10) @(posedge clk);
            #1;
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            check("ready_after_pop", 32'(cmd_ready), 32'd1);
         end
      join
      wait_drain();

      // Logic ops; flags ends with the last capture
      send(8'h0F, 8'h00, 3'b111);
      send(8'hF0, 8'h0F, 3'b100);
      wait_drain();
      check("flags_last_logic", 32'(flags), 32'b0100);

      // Randomized traffic with random response backpressure
      stim_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 150; i++) begin
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
               send(8'($urandom), 8'($urandom), 3'($urandom));
            end
            stim_done = 1'b1;
         end
         begin
            while (!stim_done) begin
               rsp_ready = 1'($urandom_range(0, 1));
               @(posedge clk); #1;
            end
         end
      join
      rsp_ready = 1'b1;
      wait_drain();

      // SETTLE=3: inputs held three cycles, capture on the fourth edge
      cmd_valid3 = 1'b1; cmd_a3 = 8'hFF; cmd_b3 = 8'h00; cmd_op3 = 3'b001;
      @(posedge clk); #1;
      cmd_valid3 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("s3_alu_a_stable", 32'(alu_a3), 32'hFF);
         check("s3_alu_sel_stable", 32'(alu_sel3), 32'd1);
         check("s3_no_rsp_yet", 32'(rsp_valid3), 32'd0);
      end
      @(posedge clk); #1;
      check("s3_rsp_valid", 32'(rsp_valid3), 32'd1);
      check("s3_rsp", 32'({rsp_nzvc3, rsp_result3}), 32'h500);
      check("s3_flags", 32'(flags3), 32'b0101);
      repeat (2) @(posedge clk);
      #1;

      // Reset mid-DRIVE with two commands queued
      cmd_valid3 = 1'b1; cmd_a3 = 8'h10; cmd_b3 = 8'h20; cmd_op3 = 3'b000;
      @(posedge clk); #1;
      cmd_a3 = 8'h21;
      @(posedge clk); #1;
      cmd_a3 = 8'h31;
      @(posedge clk); #1;
      cmd_valid3 = 1'b0;
      check("pre_rst_count3", 32'(count3), 32'd2);
      check("pre_rst_alu_a3", 32'(alu_a3), 32'h10);
      rst_n = 1'b0;
      #1;
      check("mid_rst_rsp_valid3", 32'(rsp_valid3), 32'd0);
      check("mid_rst_count3", 32'(count3), 32'd0);
      check("mid_rst_alu3", 32'({alu_a3, alu_b3, alu_sel3}), 32'd0);
      check("mid_rst_flags3", 32'(flags3), 32'd0);
      check("mid_rst_ready3", 32'(cmd_ready3), 32'd1);
      check("mid_rst_busy3", 32'(busy3), 32'd0);
      check("mid_rst_flags", 32'(flags), 32'd0);
      check("mid_rst_alu_a", 32'(alu_a), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // First command after reset is processed normally on both instances
      single(8'h12, 8'h34, 3'b000, 8'h46, 4'b0000);
      cmd_valid3 = 1'b1; cmd_a3 = 8'h01; cmd_b3 = 8'h02; cmd_op3 = 3'b000;
      @(posedge clk); #1;
      cmd_valid3 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("post_rst_rsp3", 32'({rsp_valid3, rsp_nzvc3, rsp_result3}), 32'h1003);
      @(posedge clk); #1;
      check("post_rst_idle3", 32'({busy3, rsp_valid3, count3}), 32'd0);

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
